// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared Q16.16 constants, defaults and collector state encoding
package softmax_pkg;

    localparam int WIDTH          = 32;
    localparam int FRAC_WIDTH     = 16;
    localparam int TILE_SIZE      = 8;
    localparam int TOTAL_ELEMENTS = 64;

    localparam logic [WIDTH-1:0] Q_ZERO = '0;
    localparam logic [WIDTH-1:0] Q_ONE  = WIDTH'(1) << FRAC_WIDTH;
    localparam logic [WIDTH-1:0] Q_HALF = WIDTH'(1) << (FRAC_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_FINISH  = 2'd3
    } collector_state_t;

    // Counter width helper: a degenerate depth of 1 still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/softmax_tile_collector_if.sv
// rtl/softmax_tile_collector_if.sv - control, tile input and element output bundle
interface softmax_tile_collector_if #(
    parameter int WIDTH     = softmax_pkg::WIDTH,
    parameter int TILE_SIZE = softmax_pkg::TILE_SIZE
);
    logic                        en;
    logic                        start;
    logic [TILE_SIZE*WIDTH-1:0]  tile_in;
    logic                        tile_in_valid;
    logic                        src_done;
    logic [WIDTH-1:0]            elem_out;
    logic                        elem_valid;
    logic                        elem_ready;
    logic                        elem_last;
    logic                        busy;
    logic                        done;
    logic                        err;

    modport master (
        output en, start, tile_in, tile_in_valid, src_done, elem_ready,
        input  elem_out, elem_valid, elem_last, busy, done, err
    );

    modport slave (
        input  en, start, tile_in, tile_in_valid, src_done, elem_ready,
        output elem_out, elem_valid, elem_last, busy, done, err
    );
endinterface

// File: rtl/ram_1w1r.sv
// rtl/ram_1w1r.sv - simple dual-port RAM, one write port and one registered read port
module ram_1w1r #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/softmax_tile_collector.sv
// rtl/softmax_tile_collector.sv - buffers a frame of wide tiles, then drains it one element per beat
module softmax_tile_collector #(
    parameter int WIDTH          = softmax_pkg::WIDTH,
    parameter int TILE_SIZE      = softmax_pkg::TILE_SIZE,
    parameter int TOTAL_ELEMENTS = softmax_pkg::TOTAL_ELEMENTS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    softmax_tile_collector_if.slave  bus
);
    import softmax_pkg::*;

    localparam int WORDS  = TOTAL_ELEMENTS / TILE_SIZE;
    localparam int WORD_W = TILE_SIZE * WIDTH;
    localparam int PTR_W  = clog2_min1(WORDS);
    localparam int IDX_W  = clog2_min1(TILE_SIZE);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILE_SIZE - 1);

    collector_state_t  state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [IDX_W-1:0]  idx;
    logic              pf_valid;
    logic              rd_all;
    logic              final_word;
    logic [WORD_W-1:0] word_reg;
    logic [WORD_W-1:0] rd_data;
    logic [WIDTH-1:0]  elem_out_r;
    logic              elem_valid_r;
    logic              elem_last_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    logic              in_drain;
    logic              out_adv;
    logic              take_pf;
    logic              emit;
    logic              rd_req;
    logic              last_now;
    logic [WORD_W-1:0] src_word;
    logic [WIDTH-1:0]  next_elem;

    // rd_data acts as the prefetch stage: chunk 0 comes straight from it while
    // the word is copied into word_reg, so the next read overlaps the tile.
    assign in_drain = (state == ST_DRAIN);
    assign out_adv  = !elem_valid_r || bus.elem_ready;
    assign take_pf  = in_drain && out_adv && (idx == '0) && pf_valid;
    assign emit     = in_drain && out_adv && ((idx != '0) || pf_valid);
    assign rd_req   = in_drain && !rd_all && (!pf_valid || take_pf);
    assign src_word = (idx == '0) ? rd_data : word_reg;
    assign last_now = (idx == LAST_IDX) && ((idx == '0) ? rd_all : final_word);

    always_comb begin
        next_elem = '0;
        for (int i = 0; i < TILE_SIZE; i++) begin
            if (idx == IDX_W'(i)) begin
                next_elem = src_word[(TILE_SIZE-1-i)*WIDTH +: WIDTH];
            end
        end
    end

    ram_1w1r #(
        .DATA_W (WORD_W),
        .DEPTH  (WORDS),
        .ADDR_W (PTR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (bus.en && (state == ST_COLLECT) && bus.tile_in_valid),
        .wr_addr (wr_ptr),
        .wr_data (bus.tile_in),
        .rd_en   (bus.en && rd_req),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            idx          <= '0;
            pf_valid     <= 1'b0;
            rd_all       <= 1'b0;
            final_word   <= 1'b0;
            word_reg     <= '0;
            elem_out_r   <= '0;
            elem_valid_r <= 1'b0;
            elem_last_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else if (bus.en) begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state      <= ST_COLLECT;
                        busy_r     <= 1'b1;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        idx        <= '0;
                        pf_valid   <= 1'b0;
                        rd_all     <= 1'b0;
                        final_word <= 1'b0;
                        err_r      <= 1'b0;
                    end else if (bus.tile_in_valid) begin
                        err_r <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (bus.tile_in_valid) begin
                        if (wr_ptr == LAST_PTR) begin
                            state <= ST_DRAIN;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                        end
                    end
                    // A short frame never drains; the completing write wins a tie.
                    if (bus.src_done && !(bus.tile_in_valid && (wr_ptr == LAST_PTR))) begin
                        err_r  <= 1'b1;
                        state  <= ST_FINISH;
                        done_r <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (bus.tile_in_valid) begin
                        err_r <= 1'b1;
                    end
                    if (rd_req) begin
                        pf_valid <= 1'b1;
                        if (rd_ptr == LAST_PTR) begin
                            rd_all <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + PTR_W'(1);
                        end
                    end else if (take_pf) begin
                        pf_valid <= 1'b0;
                    end
                    if (take_pf) begin
                        word_reg   <= rd_data;
                        final_word <= rd_all;
                    end
                    if (emit) begin
                        elem_out_r   <= next_elem;
                        elem_valid_r <= 1'b1;
                        elem_last_r  <= last_now;
                        idx          <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                    end else if (out_adv) begin
                        elem_valid_r <= 1'b0;
                        elem_last_r  <= 1'b0;
                    end
                    if (elem_valid_r && bus.elem_ready && elem_last_r) begin
                        state  <= ST_FINISH;
                        done_r <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    if (bus.tile_in_valid) begin
                        err_r <= 1'b1;
                    end
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.elem_out   = elem_out_r;
    assign bus.elem_valid = elem_valid_r;
    assign bus.elem_last  = elem_last_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;
endmodule
